// File: rtl/mem_bus_master_if.sv
// Core request / memory bus bundle for mem_bus_master.
// master = the bus master block, slave = core plus memory side.
interface mem_bus_master_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWr;
    logic [15:0] ReqAddr;
    logic [15:0] ReqData;
    logic        RspValid;
    logic [15:0] RspData;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic [15:0] DataIn;

    modport master (
        input  ReqValid, ReqWr, ReqAddr, ReqData, DataIn,
        output ReqReady, RspValid, RspData, Addr, RD, WR, DataOut
    );

    modport slave (
        output ReqValid, ReqWr, ReqAddr, ReqData, DataIn,
        input  ReqReady, RspValid, RspData, Addr, RD, WR, DataOut
    );
endinterface

// File: rtl/mem_bus_master.sv
// Queued memory bus master: request FIFO feeding a two-cycle ADDR/DATA bus FSM.
// Optional macro CVP14_HALT_DETECT_EN: popping address 16'hFFFF parks the FSM in HALT.
module mem_bus_master #(
    parameter int DEPTH = 2
) (
    input  logic             Clk1,
    input  logic             Reset,
    mem_bus_master_if.master bus,
    output logic             Busy,
    output logic             Halted
);
    localparam int PW = (DEPTH == 4) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HALT} state_t;

    state_t        state;
    logic [32:0]   fifo [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          halt_hit;
    logic [32:0]   head;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign bus.ReqReady = !full && (state != HALT);
    assign push         = bus.ReqValid && bus.ReqReady;
    assign pop          = !empty && ((state == IDLE) || (state == DATA));
    assign head         = fifo[rptr];
    assign Busy         = !empty || (state != IDLE);

`ifdef CVP14_HALT_DETECT_EN
    assign halt_hit = (head[31:16] == 16'hFFFF);
    assign Halted   = (state == HALT);
`else
    assign halt_hit = 1'b0;
    assign Halted   = 1'b0;
`endif

    // FIFO storage: entry is {wr, addr, data}, written on accept
    always_ff @(posedge Clk1) begin
        if (push) begin
            fifo[wptr] <= {bus.ReqWr, bus.ReqAddr, bus.ReqData};
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves count alone
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus FSM: ADDR then DATA per transaction, back-to-back when queued
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state        <= IDLE;
            bus.Addr     <= '0;
            bus.DataOut  <= '0;
            bus.RD       <= 1'b0;
            bus.WR       <= 1'b0;
            bus.RspValid <= 1'b0;
            bus.RspData  <= '0;
        end else begin
            bus.RspValid <= 1'b0;
            unique case (state)
                IDLE, DATA: begin
                    if ((state == DATA) && bus.RD) begin
                        bus.RspData  <= bus.DataIn;
                        bus.RspValid <= 1'b1;
                    end
                    if (pop && halt_hit) begin
                        state  <= HALT;
                        bus.RD <= 1'b0;
                        bus.WR <= 1'b0;
                    end else if (pop) begin
                        state       <= ADDR;
                        bus.Addr    <= head[31:16];
                        bus.RD      <= !head[32];
                        bus.WR      <= head[32];
                        bus.DataOut <= head[15:0];
                    end else begin
                        state  <= IDLE;
                        bus.RD <= 1'b0;
                        bus.WR <= 1'b0;
                    end
                end
                ADDR: state <= DATA;
                HALT: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_bus_master;
    localparam int DEPTH = 2;
`ifdef CVP14_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    logic Clk1 = 1'b0;
    logic Reset;
    logic Busy;
    logic Halted;

    mem_bus_master_if bus();

    mem_bus_master #(.DEPTH(DEPTH)) dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus),
        .Busy  (Busy),
        .Halted(Halted)
    );

    always #5 Clk1 = ~Clk1;

    logic [15:0] mem  [0:65535];
    logic [15:0] mmem [0:65535];

    assign bus.DataIn = mem[bus.Addr];

    int errors = 0;
    int checks = 0;
    int stalls = 0;

    req_t        q[$];
    req_t        cur = '0;
    int          t = 0;
    logic        m_rv = 1'b0;
    logic [15:0] m_rd = '0;
    logic        m_halt = 1'b0;
    bit          chk_en = 1'b0;
    logic [15:0] alog[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference model: a request queue and a 2-cycle bus slot
    task automatic model_step();
        req_t e;
        bit   acc;
        if (Reset) begin
            q.delete();
            t      = 0;
            cur    = '0;
            m_rv   = 1'b0;
            m_rd   = '0;
            m_halt = 1'b0;
            chk_en = 1'b1;
            return;
        end
        acc  = bus.ReqValid && (q.size() < DEPTH) && !m_halt;
        m_rv = 1'b0;
        if (t == 1) begin
            if (cur.wr) begin
                mmem[cur.addr] = cur.data;
            end else begin
                m_rv = 1'b1;
                m_rd = mmem[cur.addr];
            end
        end
        if (t == 2) begin
            t = 1;
        end else if (!m_halt && q.size() != 0) begin
            e = q.pop_front();
            if (HALT_EN && e.addr == 16'hFFFF) begin
                m_halt = 1'b1;
                t      = 0;
            end else begin
                cur = e;
                t   = 2;
            end
        end else begin
            t = 0;
        end
        if (acc) begin
            q.push_back({bus.ReqWr, bus.ReqAddr, bus.ReqData});
        end
    endtask

    // Memory write port and model advance on each rising edge
    initial forever begin
        @(posedge Clk1);
        if (!Reset && bus.WR === 1'b1) begin
            mem[bus.Addr] = bus.DataOut;
        end
        model_step();
    end

    // Per-cycle comparison of every DUT output against the model
    initial forever begin
        logic [53:0] exp_v;
        logic [53:0] act_v;
        @(negedge Clk1);
        if (chk_en) begin
            exp_v = {(q.size() < DEPTH) && !m_halt, m_rv, m_rd, cur.addr,
                     (t != 0) && !cur.wr, (t != 0) && cur.wr, cur.data,
                     (q.size() != 0) || (t != 0) || m_halt, m_halt};
            act_v = {bus.ReqReady, bus.RspValid, bus.RspData, bus.Addr,
                     bus.RD, bus.WR, bus.DataOut, Busy, Halted};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_cmp @%0t got=%h want=%h (rdy,rv,rsp,addr,rd,wr,dout,busy,halt)",
                         $time, act_v, exp_v);
            end
        end
    end

    // Log bus address for each active bus cycle
    initial forever begin
        @(negedge Clk1);
        if (chk_en && (bus.RD === 1'b1 || bus.WR === 1'b1)) begin
            alog.push_back(bus.Addr);
        end
    end

    task automatic push(input logic w, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        bus.ReqValid = 1'b1;
        bus.ReqWr    = w;
        bus.ReqAddr  = a;
        bus.ReqData  = d;
        while (!bus.ReqReady && n < 50) begin
            @(negedge Clk1);
            n++;
            stalls++;
        end
        chk1("push_timeout", n >= 50, 1'b0);
        @(negedge Clk1);
        bus.ReqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            @(negedge Clk1);
            n++;
        end
        chk1("idle_timeout", n >= 100, 1'b0);
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
        mem[a]  = v;
        mmem[a] = v;
    endtask

    req_t        tbl [12];
    logic [15:0] seq;
    logic [15:0] rvn;
    logic        act;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[16'(i)]  = 16'(i * 7 + 3);
            mmem[16'(i)] = 16'(i * 7 + 3);
        end
        bus.ReqValid = 1'b0;
        bus.ReqWr    = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqData  = '0;
        Reset        = 1'b1;
        repeat (2) @(negedge Clk1);
        chk1("rst_ready", bus.ReqReady, 1'b1);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_rd", bus.RD, 1'b0);
        chk1("rst_wr", bus.WR, 1'b0);
        chk1("rst_rv", bus.RspValid, 1'b0);
        chk16("rst_rspdata", bus.RspData, 16'h0000);
        chk16("rst_addr", bus.Addr, 16'h0000);
        chk16("rst_dout", bus.DataOut, 16'h0000);
        chk1("rst_halted", Halted, 1'b0);
        Reset = 1'b0;
        @(negedge Clk1);

        // single read latency
        set_mem(16'h0010, 16'hBEEF);
        push(1'b0, 16'h0010, 16'h0000);
        chk1("rd_k1_busy", Busy, 1'b1);
        chk1("rd_k1_rd", bus.RD, 1'b0);
        @(negedge Clk1);
        chk1("rd_k2_rd", bus.RD, 1'b1);
        chk16("rd_k2_addr", bus.Addr, 16'h0010);
        @(negedge Clk1);
        chk1("rd_k3_rd", bus.RD, 1'b1);
        chk1("rd_k3_rv", bus.RspValid, 1'b0);
        @(negedge Clk1);
        chk1("rd_k4_rv", bus.RspValid, 1'b1);
        chk16("rd_k4_data", bus.RspData, 16'hBEEF);
        chk1("rd_k4_rd", bus.RD, 1'b0);
        @(negedge Clk1);
        chk1("rd_k5_rv", bus.RspValid, 1'b0);
        chk1("rd_k5_busy", Busy, 1'b0);
        chk16("rd_k5_hold", bus.RspData, 16'hBEEF);

        // write then read back-to-back
        push(1'b1, 16'h0020, 16'h1234);
        push(1'b0, 16'h0020, 16'h0000);
        seq = '0;
        rvn = '0;
        for (int i = 0; i < 5; i++) begin
            seq = {seq[13:0], bus.WR, bus.RD};
            rvn = rvn + {15'b0, bus.RspValid};
            @(negedge Clk1);
        end
        chk16("wr_rd_seq", seq, 16'b0000001010010100);
        chk16("wr_rd_rvcount", rvn, 16'd1);
        chk16("wr_rd_data", bus.RspData, 16'h1234);

        // back-pressure and ordering with four quick requests
        wait_idle();
        alog.delete();
        stalls = 0;
        push(1'b0, 16'h0030, 16'h0000);
        push(1'b1, 16'h0031, 16'hA001);
        push(1'b0, 16'h0032, 16'h0000);
        push(1'b1, 16'h0033, 16'hA003);
        wait_idle();
        chk1("bp_stalled", stalls > 0, 1'b1);
        chk16("bp_log_len", 16'(alog.size()), 16'd8);
        for (int i = 0; i < 8 && i < alog.size(); i++) begin
            chk16("bp_order", alog[i], 16'(16'h0030 + i / 2));
        end

        // reset in the DATA cycle of a read, with a write queued behind it
        push(1'b0, 16'h0010, 16'h0000);
        push(1'b1, 16'h0040, 16'h5555);
        @(negedge Clk1);
        chk1("ra_in_data", bus.RD, 1'b1);
        Reset = 1'b1;
        @(negedge Clk1);
        Reset = 1'b0;
        chk1("ra_rd", bus.RD, 1'b0);
        chk1("ra_rv", bus.RspValid, 1'b0);
        chk1("ra_busy", Busy, 1'b0);
        chk1("ra_ready", bus.ReqReady, 1'b1);
        act = 1'b0;
        repeat (3) begin
            @(negedge Clk1);
            act = act | bus.RD | bus.WR | bus.RspValid;
        end
        chk1("ra_quiet", act, 1'b0);
        chk16("ra_no_write", mem[16'h0040], 16'h01C3);

        // address 16'hFFFF
`ifdef CVP14_HALT_DETECT_EN
        push(1'b0, 16'hFFFF, 16'h0000);
        @(negedge Clk1);
        chk1("halt_flag", Halted, 1'b1);
        chk1("halt_rd", bus.RD, 1'b0);
        chk1("halt_wr", bus.WR, 1'b0);
        chk1("halt_ready", bus.ReqReady, 1'b0);
        chk1("halt_busy", Busy, 1'b1);
        bus.ReqValid = 1'b1;
        bus.ReqWr    = 1'b1;
        bus.ReqAddr  = 16'h0050;
        bus.ReqData  = 16'h7777;
        act = 1'b0;
        repeat (3) begin
            @(negedge Clk1);
            act = act | bus.RD | bus.WR | bus.ReqReady | !Halted;
        end
        bus.ReqValid = 1'b0;
        chk1("halt_sticky", act, 1'b0);
        Reset = 1'b1;
        @(negedge Clk1);
        Reset = 1'b0;
        chk1("halt_cleared", Halted, 1'b0);
        chk1("halt_ready_back", bus.ReqReady, 1'b1);
`else
        set_mem(16'hFFFF, 16'hCAFE);
        push(1'b0, 16'hFFFF, 16'h0000);
        @(negedge Clk1);
        chk1("ffff_rd", bus.RD, 1'b1);
        chk16("ffff_addr", bus.Addr, 16'hFFFF);
        repeat (2) @(negedge Clk1);
        chk1("ffff_rv", bus.RspValid, 1'b1);
        chk16("ffff_data", bus.RspData, 16'hCAFE);
        chk1("ffff_halted", Halted, 1'b0);
`endif

        // mixed directed traffic with varying gaps
        wait_idle();
        tbl[0]  = {1'b1, 16'h0100, 16'h1111};
        tbl[1]  = {1'b1, 16'h0101, 16'h2222};
        tbl[2]  = {1'b0, 16'h0100, 16'h0000};
        tbl[3]  = {1'b0, 16'h0101, 16'h0000};
        tbl[4]  = {1'b1, 16'h0100, 16'h3333};
        tbl[5]  = {1'b0, 16'h0100, 16'h0000};
        tbl[6]  = {1'b0, 16'h0200, 16'h0000};
        tbl[7]  = {1'b1, 16'h0200, 16'h4444};
        tbl[8]  = {1'b0, 16'h0200, 16'h0000};
        tbl[9]  = {1'b1, 16'hFFFE, 16'h5555};
        tbl[10] = {1'b0, 16'hFFFE, 16'h0000};
        tbl[11] = {1'b0, 16'h0000, 16'h0000};
        for (int i = 0; i < 12; i++) begin
            push(tbl[i].wr, tbl[i].addr, tbl[i].data);
            repeat (i % 3) @(negedge Clk1);
        end
        wait_idle();
        @(negedge Clk1);
        chk16("mix_last_rsp", bus.RspData, 16'h0003);
        chk16("mix_mem_fffe", mem[16'hFFFE], 16'h5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
